// File: rtl/sfifo_reader.sv
// Read-side controller for a flagless single-clock register FIFO: tracks occupancy
// from the write strobe, pops words into a two-entry output buffer, flags overflow.
module sfifo_reader #(
  parameter int DW      = 32,
  parameter int LEN_LOG = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               flush,
  input  logic               enq,
  input  logic [DW-1:0]      fifo_dat,
  output logic               deq,
  output logic               o_valid,
  output logic [DW-1:0]      o_data,
  input  logic               i_ready,
  output logic [LEN_LOG:0]   level,
  output logic               empty,
  output logic               ovf
);

  localparam logic [LEN_LOG:0] CNT_ZERO = {(LEN_LOG+1){1'b0}};
  localparam logic [LEN_LOG:0] CNT_ONE  = {{LEN_LOG{1'b0}}, 1'b1};
  localparam logic [LEN_LOG:0] CNT_FULL = CNT_ONE << LEN_LOG;
  localparam logic [DW-1:0]    DAT_ZERO = {DW{1'b0}};

  logic [LEN_LOG:0] cnt_q, cnt_d;
  logic [1:0]       ob_cnt_q, ob_cnt_d;
  logic [DW-1:0]    head_q, head_d;
  logic [DW-1:0]    skid_q, skid_d;
  logic             ovf_q, ovf_d;
  logic             deq_s;
  logic             pop_s;

  // Next-state logic for the occupancy counter, overflow flag and output buffer.
  always_comb begin
    cnt_d    = cnt_q;
    ob_cnt_d = ob_cnt_q;
    head_d   = head_q;
    skid_d   = skid_q;
    ovf_d    = ovf_q;
    pop_s    = (ob_cnt_q != 2'd0) && i_ready;
    // Fetch decision uses registered state only, keeping i_ready off the deq path.
    deq_s    = (cnt_q != CNT_ZERO) && (ob_cnt_q != 2'd2) && !flush;

    if (flush) begin
      cnt_d    = CNT_ZERO;
      ob_cnt_d = 2'd0;
      head_d   = DAT_ZERO;
      skid_d   = DAT_ZERO;
      ovf_d    = 1'b0;
    end else begin
      if (enq && !deq_s) begin
        if (cnt_q == CNT_FULL) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else if (deq_s && !enq) begin
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end

      case ({deq_s, pop_s})
        2'b10: begin
          if (ob_cnt_q == 2'd0) begin
            head_d = fifo_dat;
          end else begin
            skid_d = fifo_dat;
          end
          ob_cnt_d = ob_cnt_q + 2'd1;
        end
        // Fetch and pop together only happen with one word buffered.
        2'b11: begin
          head_d   = fifo_dat;
          ob_cnt_d = ob_cnt_q;
        end
        2'b01: begin
          if (ob_cnt_q == 2'd2) begin
            head_d = skid_q;
          end else begin
            head_d = head_q;
          end
          ob_cnt_d = ob_cnt_q - 2'd1;
        end
        default: begin
          ob_cnt_d = ob_cnt_q;
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q    <= CNT_ZERO;
      ob_cnt_q <= 2'd0;
      head_q   <= DAT_ZERO;
      skid_q   <= DAT_ZERO;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ob_cnt_q <= ob_cnt_d;
      head_q   <= head_d;
      skid_q   <= skid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign deq     = deq_s;
  assign o_valid = (ob_cnt_q != 2'd0);
  assign o_data  = head_q;
  assign level   = cnt_q;
  assign empty   = (cnt_q == CNT_ZERO) && (ob_cnt_q == 2'd0);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_sfifo_reader.sv
// Self-checking bench for sfifo_reader: per-cycle vector table plus a data scoreboard
// fed by a behavioural model of the companion register FIFO.
module tb_sfifo_reader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        flush;
  logic        enq;
  logic [31:0] wdat;
  logic [31:0] fifo_dat;
  logic        deq;
  logic        o_valid;
  logic [31:0] o_data;
  logic        i_ready;
  logic [2:0]  level;
  logic        empty;
  logic        ovf;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        enq;
    logic [31:0] wdat;
    logic        ir;
    logic        fl;
    logic        e_deq;
    logic        e_val;
    logic [2:0]  e_lvl;
    logic        e_emp;
    logic        e_ovf;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];

  logic [31:0] mem [4];
  logic [1:0]  wp, rp;

  always #5 CLK = ~CLK;

  sfifo_reader #(.DW(32), .LEN_LOG(2)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .enq(enq), .fifo_dat(fifo_dat),
    .deq(deq), .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .level(level), .empty(empty), .ovf(ovf)
  );

  // Companion flagless register FIFO.
  assign fifo_dat = mem[rp];
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp <= 2'd0;
      rp <= 2'd0;
    end else if (flush) begin
      wp <= 2'd0;
      rp <= 2'd0;
    end else begin
      if (enq) begin
        mem[wp] <= wdat;
        wp <= wp + 2'd1;
      end
      if (deq) rp <= rp + 2'd1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else passed++;
  endtask

  task automatic add(input logic e, input logic [31:0] d, input logic ir, input logic fl,
                     input logic xdeq, input logic xval, input logic [2:0] xlvl,
                     input logic xemp, input logic xovf);
    vec_t v;
    v.enq = e; v.wdat = d; v.ir = ir; v.fl = fl;
    v.e_deq = xdeq; v.e_val = xval; v.e_lvl = xlvl; v.e_emp = xemp; v.e_ovf = xovf;
    vecs.push_back(v);
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      @(posedge CLK);
      #1;
      enq = vecs[i].enq; wdat = vecs[i].wdat; i_ready = vecs[i].ir; flush = vecs[i].fl;
      if (vecs[i].enq && !vecs[i].fl) exp_q.push_back(vecs[i].wdat);
      @(negedge CLK);
      chk("deq",   {31'd0, deq},     {31'd0, vecs[i].e_deq});
      chk("valid", {31'd0, o_valid}, {31'd0, vecs[i].e_val});
      chk("level", {29'd0, level},   {29'd0, vecs[i].e_lvl});
      chk("empty", {31'd0, empty},   {31'd0, vecs[i].e_emp});
      chk("ovf",   {31'd0, ovf},     {31'd0, vecs[i].e_ovf});
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_underrun", o_data, 32'hDEAD_BEEF);
        end else begin
          chk("o_data", o_data, exp_q[0]);
          if (i_ready) void'(exp_q.pop_front());
        end
      end
      if (vecs[i].fl) exp_q.delete();
    end
    vecs.delete();
    @(posedge CLK);
    #1;
    enq = 1'b0; flush = 1'b0;
  endtask

  task automatic add_single();
    add(1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    add(1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
    add(1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    add(1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 32'd0;
    RST = 1'b1; flush = 1'b0; enq = 1'b0; wdat = 32'd0; i_ready = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_deq",   {31'd0, deq},     32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_data",  o_data,           32'd0);
    chk("rst_level", {29'd0, level},   32'd0);
    chk("rst_empty", {31'd0, empty},   32'd1);
    chk("rst_ovf",   {31'd0, ovf},     32'd0);
    RST = 1'b0;

    // Idle
    for (int i = 0; i < 10; i++) add(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    add_single();
    // Streaming 1..8
    add(1'b1, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    add(1'b1, 32'd2, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
    for (int i = 3; i <= 8; i++) add(1'b1, 32'(i), 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
    add(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
    add(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    add(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    // Back-pressure
    add(1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    add(1'b1, 32'd2, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
    add(1'b1, 32'd3, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
    add(1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    add(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    add(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    add(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
    add(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
    add(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    add(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    run_table();
    chk("sb_drained", exp_q.size(), 32'd0);

    // Overflow, sticky flag, flush
    add(1'b1, 32'h21, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    add(1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
    add(1'b1, 32'h23, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
    add(1'b1, 32'h24, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    add(1'b1, 32'h25, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    add(1'b1, 32'h26, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    add(1'b1, 32'h27, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    add(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1);
    add(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1);
    add(1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1);
    add(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    // Flush masks a pending fetch and drops a concurrent enq
    add(1'b1, 32'h31, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    add(1'b1, 32'h32, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    add(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    run_table();

    // Reset mid-stream with o_valid=1 and level=3
    add(1'b1, 32'h41, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    add(1'b1, 32'h42, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
    add(1'b1, 32'h43, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
    add(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    add(1'b1, 32'h45, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    add(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    run_table();
    chk("pre_rst_level", {29'd0, level}, 32'd3);
    #2;
    RST = 1'b1;
    #1;
    chk("mid_rst_deq",   {31'd0, deq},     32'd0);
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_data",  o_data,           32'd0);
    chk("mid_rst_level", {29'd0, level},   32'd0);
    chk("mid_rst_empty", {31'd0, empty},   32'd1);
    chk("mid_rst_ovf",   {31'd0, ovf},     32'd0);
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b0;
    add_single();
    run_table();
    chk("sb_final", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sfifo_reader.md
# sfifo_reader

Read-side controller for a flagless, single-clock register FIFO. It mirrors the FIFO's write strobe to track occupancy and issues read-pointer advance pulses. Popped words are moved into a two-entry output buffer that presents them on a valid/ready stream, with registered outputs. It sits between a free-running register FIFO and a back-pressured consumer, providing the level, empty and overflow information the FIFO itself does not have.

## Interface
- DW, 32, data width in bits
- LEN_LOG, 2, log2 of companion FIFO depth; LEN = 1 << LEN_LOG
- CLK  in  1  clock; all state on rising edge
- RST  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of all state; integrator ties it to the FIFO's pointer resets
- enq  in  1  copy of the FIFO write strobe; one word written per cycle when high
- fifo_dat  in  DW  FIFO head word; combinationally valid whenever the FIFO is non-empty
- deq  out  1  FIFO read-pointer advance strobe
- o_valid  out  1  output stream word available
- o_data  out  DW  output stream word
- i_ready  in  1  consumer accepts o_data when o_valid && i_ready
- level  out  LEN_LOG+1  words held in the FIFO, excluding the output buffer
- empty  out  1  level == 0 && o_valid == 0
- ovf  out  1  sticky overflow flag

## Operation
- Occupancy counter `cnt` (LEN_LOG+1 bits) drives `level`.
  - enq && !deq: cnt+1.
  - deq && !enq: cnt−1.
  - Both or neither: cnt unchanged.
- Overflow: enq && !deq && cnt == LEN sets `ovf`.
  - cnt saturates at LEN.
  - The FIFO has lost a word; this block does not try to recover it.
  - `ovf` clears only on RST or flush.
- Fetch rule: deq = (cnt != 0) && (ob_cnt != 2) && !flush.
  - Depends only on registered state, so there is no combinational path from i_ready to deq.
  - On a deq cycle, fifo_dat is captured into the output buffer at the same edge.
- Output buffer: head register, skid register, and `ob_cnt` in 0..2.
  - pop = o_valid && i_ready.
  - Fetch with ob_cnt 0, or ob_cnt 1 with pop: word goes to the head.
  - Fetch with ob_cnt 1 without pop: word goes to the skid.
  - Pop with ob_cnt 2: skid moves to the head.
  - ob_cnt' = ob_cnt + deq − pop.
- o_valid = (ob_cnt != 0). o_data = head register.
- Ordering is strictly FIFO; no word is duplicated or dropped unless `ovf` is set.
- flush: cnt, ob_cnt and ovf all go to 0 at the next edge, and deq is forced low that cycle. A concurrent enq is ignored; the FIFO's pointers are reset by the same flush.

## Timing
- Reset (RST high, asynchronous) values: deq=0, o_valid=0, o_data=0, level=0, empty=1, ovf=0. Buffer registers are cleared.
- Latency: enq at edge k (first word, idle block) gives deq high in cycle k→k+1, and o_valid=1 with o_data = word after edge k+1.
- Throughput: one word per cycle sustained while cnt > 0 and i_ready is held high.
- Back-pressure: i_ready low fills head then skid, after which deq stops. Resuming i_ready gives a pop on the same cycle, and deq restarts one cycle later.
- Wrap-around: cnt arithmetic is modular-safe because cnt ≤ LEN always holds. Pointer wrap is the FIFO's own business.
- RST mid-transfer: all state clears immediately; in-flight words are discarded.

## Test plan
- Reset/idle: RST pulse, no enq → level=0, empty=1, deq=0, o_valid=0, ovf=0 for 10 cycles.
- Single word: enq one cycle with FIFO head 0xA5A5_0001, i_ready=1 → deq one cycle later; o_valid one cycle after that with o_data=0xA5A5_0001; level returns to 0; empty=1 afterward.
- Streaming: 8 back-to-back enq of 1..8 (LEN=4), i_ready=1 → outputs 1..8 in order at 1 per cycle; level never exceeds 1; ovf=0.
- Back-pressure: 4 enq with i_ready=0 →
  - ob_cnt reaches 2 and deq stops.
  - level=2, o_data=1 held.
  - Raising i_ready yields 1,2,3,4 on consecutive cycles.
- Overflow: i_ready=0, 7 enq → buffer takes 2, FIFO holds 4, and the 7th enq sets ovf=1 with level saturated at 4. ovf stays set until flush, which returns level=0, o_valid=0, ovf=0.
- Reset mid-stream: assert RST while o_valid=1 and level=3 → all outputs at reset values within the same cycle; the first new enq afterwards behaves as in the single-word case.
